// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - iterative HI/LO multiply/divide sequencer (optional MDU_ACCUM_EN adds MADD/MSUB)
module mdu_sequencer #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic        abort,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
`ifdef MDU_ACCUM_EN
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
`endif
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } stateT;

  stateT       state;
  logic [5:0]  cnt;
  logic [3:0]  opReg;
  logic [31:0] divisor;
  logic [63:0] acc;
  logic        negRes;
  logic        negRem;

  logic        isMul;
  logic        isDiv;
  logic        isSigned;
  logic        canIssue;
  logic        accept;
  logic [31:0] absA;
  logic [31:0] absB;
  logic [32:0] mulSum;
  logic [63:0] mulNext;
  logic [32:0] divPartial;
  logic [32:0] divDiff;
  logic        noBorrow;
  logic [31:0] remNext;
  logic [63:0] divNext;
  logic [63:0] prodFixed;
  logic [31:0] quoFixed;
  logic [31:0] remFixed;

  // Issue decode, operand magnitudes and the combinational stall toward the pipeline
  always_comb begin
    isMul    = (op == OP_MULT) || (op == OP_MULTU);
    isSigned = (op == OP_MULT) || (op == OP_DIV);
`ifdef MDU_ACCUM_EN
    isMul    = isMul || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    isSigned = isSigned || (op == OP_MADD) || (op == OP_MSUB);
`endif
    isDiv    = (op == OP_DIV) || (op == OP_DIVU);
    canIssue = start && !abort && (state == IDLE);
    // Divide by zero still stalls for its issue cycle but never starts a sequence
    accept   = canIssue && (isMul || (isDiv && (srcb != 32'd0)));
    busy     = (canIssue && (isMul || isDiv)) || (state != IDLE);
    absA     = (isSigned && srca[31]) ? -srca : srca;
    absB     = (isSigned && srcb[31]) ? -srcb : srcb;
  end

  // One iteration of shift-add multiply and restoring divide; acc holds {hi half, lo half}
  always_comb begin
    mulSum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, divisor} : 33'd0);
    mulNext    = {mulSum, acc[31:1]};
    divPartial = {acc[63:32], acc[31]};
    divDiff    = divPartial - {1'b0, divisor};
    noBorrow   = (divPartial >= {1'b0, divisor});
    remNext    = noBorrow ? divDiff[31:0] : divPartial[31:0];
    divNext    = {remNext, acc[30:0], noBorrow};
  end

  // Sign correction applied in FIX
  always_comb begin
    prodFixed = negRes ? -acc : acc;
    quoFixed  = negRes ? -acc[31:0] : acc[31:0];
    remFixed  = negRem ? -acc[63:32] : acc[63:32];
  end

  // Sequencer FSM with HI/LO commit and done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 6'd0;
      opReg   <= 4'd0;
      divisor <= 32'd0;
      acc     <= 64'd0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              opReg   <= op;
              divisor <= absB;
              acc     <= {32'd0, absA};
              negRes  <= isSigned && (srca[31] ^ srcb[31]);
              negRem  <= isSigned && srca[31];
              cnt     <= 6'(ITER);
              state   <= CALC;
            end else if (start && (op == OP_MTHI)) begin
              hi <= srca;
            end else if (start && (op == OP_MTLO)) begin
              lo <= srca;
            end
          end
          CALC: begin
            acc <= ((opReg == OP_DIV) || (opReg == OP_DIVU)) ? divNext : mulNext;
            cnt <= cnt - 6'd1;
            if (cnt == 6'd1) begin
              state <= FIX;
            end
          end
          FIX: begin
            case (opReg)
              OP_MULT, OP_MULTU: {hi, lo} <= prodFixed;
              OP_DIV, OP_DIVU: begin
                hi <= remFixed;
                lo <= quoFixed;
              end
`ifdef MDU_ACCUM_EN
              OP_MADD, OP_MADDU: {hi, lo} <= {hi, lo} + prodFixed;
              OP_MSUB, OP_MSUBU: {hi, lo} <= {hi, lo} - prodFixed;
`endif
              default: ;
            endcase
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Iterative multiply/divide sequencer for the execute stage: accepts one HI/LO operation per issue, runs a radix-2 shift-add multiplier or restoring divider for a fixed 32 iterations, applies sign correction, and commits HI/LO. It is a drop-in synthesizable replacement for the behavioural delay model in the E stage. It drives `busy` to the pipeline controller, which stalls MD-class instructions and `mfhi`/`mflo` while `busy` is high.

## Interface
Parameters:
- `ITER`, 32: iteration count; fixed by operand width and not to be overridden.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  issue enable from the pipeline controller (E stage not stalled, not flushed).
- `op`  in  4  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU, 9 MTHI, 10 MTLO; 11–15 are treated as NONE.
- `srca`  in  32  rs operand.
- `srcb`  in  32  rt operand.
- `abort`  in  1  kills the in-flight operation (exception or interrupt flush).
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `busy`  out  1  operation accepted or in progress.
- `done`  out  1  one-cycle pulse on the cycle after HI/LO commit.

## Operation
- States: IDLE, CALC, FIX.
- **IDLE.** `start` with a multiply-class op, or DIV/DIVU with `srcb != 0`:
  - Latch the op.
  - Latch absolute values of `srca`/`srcb` for signed ops; `abs(0x80000000) = 0x80000000` as a 32-bit unsigned value.
  - Latch the result-sign flags.
  - Set `cnt = 32`, go to CALC.
- **Divide by zero.** `start` with DIV/DIVU and `srcb == 0` is a no-op: HI/LO unchanged, `busy` only combinationally high that cycle.
- **IDLE, MTHI/MTLO.** `start` with MTHI writes `hi <= srca`; MTLO writes `lo <= srca`. Single cycle, no state change.
- **CALC.** One iteration per cycle, then `cnt` decrements. At `cnt == 1` the next state is FIX.
  - Multiply: 64-bit accumulator; conditional add of multiplicand, then shift right.
  - Divide: 33-bit trial subtract of divisor from `{rem, next dividend bit}`; quotient bit = no borrow.
- **FIX.**
  - Negate the product if the operand signs differ (signed ops only).
  - Negate the quotient if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Commit to HI/LO:
    - MULT/MULTU: `{hi,lo} <= product`.
    - DIV/DIVU: `hi <= rem`, `lo <= quo`.
    - MADD/MADDU: `{hi,lo} <= {hi,lo} + product`.
    - MSUB/MSUBU: `{hi,lo} <= {hi,lo} - product`.
    - All arithmetic is 64-bit modulo.
  - Return to IDLE and assert `done` next cycle.
- **`busy`** = `(start & accepted-op) | (state != IDLE)`. It is combinational in the issue cycle so the pipeline stalls the following instruction.
- **Ignored inputs.**
  - `start` while not IDLE is ignored; the controller guarantees it does not occur.
  - MTHI/MTLO while busy are ignored.
- **`abort`.** Any state returns to IDLE at the next edge; HI/LO unchanged; no `done`. `abort` and `start` in the same IDLE cycle: `abort` wins, nothing is accepted, MTHI/MTLO are not written.
- **`reset`.** Overrides everything, including mid-operation.

## Timing
- Reset values:
  - `hi`, `lo`, `busy`, `done` = 0.
  - state = IDLE, `cnt` = 0, all internal operand and accumulator registers = 0.
- Issue at edge E0 (`start` high in the preceding cycle).
- CALC covers edges E1..E32; FIX commits at E33.
- New HI/LO are visible after E33; `busy` is low after E33; `done` is high for the cycle after E33.
- Total: 34 edges from issue to commit, identical for multiply and divide.
- MTHI/MTLO: visible after one edge.
- `done` deasserts after one cycle unconditionally.

## Configuration
- `MDU_ACCUM_EN` defined: MADD, MADDU, MSUB, MSUBU are supported as above.
- Not defined: ops 5–8 decode as NONE. No `busy`, no HI/LO change, and the 64-bit accumulate adder is removed.

## Test plan
- MULT 7 × 0xFFFFFFFD -> after 34 edges `hi=0xFFFFFFFF`, `lo=0xFFFFFFEB`; `busy` high 34 cycles; one `done` pulse.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `hi=0xFFFFFFFE`, `lo=0x00000001`.
- DIV cases:
  - 0xFFFFFFF9 ÷ 2 -> `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`.
  - 0x80000000 ÷ 0xFFFFFFFF -> `lo=0x80000000`, `hi=0`.
- DIVU 5 ÷ 0 -> `busy` low after the issue cycle; HI/LO hold prior values; no `done`.
- MTHI 0x12345678 then MADD 3 × 4 (with `MDU_ACCUM_EN`), starting from `lo=0` -> `hi=0x12345678`, `lo=0x0000000C`; without the macro, HI/LO unchanged.
- MULT issued, `abort` on edge E10 -> `busy` low after E10, HI/LO unchanged, no `done`. `reset` at E20 of a DIV -> all outputs 0.
